// File: rtl/ksa_mp_seq.sv
// Kogge-Stone adder plus a multi-precision sequencer that streams WORDS slices through it,
// least significant word first, carrying between slices through a single register.

module KSA #(
  parameter int unsigned N = 64
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N:0]   S
);
  // Position 0 holds Cin as a generate term, so prefix position i is the carry into bit i.
  localparam int unsigned M  = N + 1;
  localparam int unsigned Lv = $clog2(M);

  for (genvar l = 0; l <= Lv; l++) begin : g_lvl
    logic [M-1:0] g;
    logic [M-1:0] p;
    if (l == 0) begin : g_init
      assign g = {A & B, Cin};
      assign p = {A ^ B, 1'b0};
    end else begin : g_step
      localparam int unsigned D = 1 << (l - 1);
      for (genvar i = 0; i < M; i++) begin : g_bit
        if (i >= D) begin : g_merge
          assign g[i] = g_lvl[l-1].g[i] | (g_lvl[l-1].p[i] & g_lvl[l-1].g[i-D]);
          assign p[i] = g_lvl[l-1].p[i] & g_lvl[l-1].p[i-D];
        end else begin : g_pass
          assign g[i] = g_lvl[l-1].g[i];
          assign p[i] = g_lvl[l-1].p[i];
        end
      end
    end
  end

  assign S = {g_lvl[Lv].g[N], g_lvl[0].p[N:1] ^ g_lvl[Lv].g[N-1:0]};

  logic unused_p;
  assign unused_p = ^g_lvl[Lv].p;

endmodule

module ksa_mp_seq #(
  parameter int unsigned N     = 64,
  parameter int unsigned WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORDS*N-1:0] in_a,
  input  logic [WORDS*N-1:0] in_b,
  input  logic               in_cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORDS*N:0]   out_sum,
  output logic               busy
);
  localparam int unsigned W    = WORDS * N;
  localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W:0]      sum_q;
  logic [IdxW-1:0] idx_q;
  logic            carry_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            busy_q;
  logic [N:0]      s;
  logic [W-1:0]    sum_shift;

  KSA #(.N(N)) u_ksa (
    .A   (a_q[N-1:0]),
    .B   (b_q[N-1:0]),
    .Cin (carry_q),
    .S   (s)
  );

  // Operands shift down one slice per RUN cycle so the live slice always sits at bit 0;
  // finished slices enter sum_q from the top and are in place after WORDS shifts.
  if (WORDS == 1) begin : g_one
    assign sum_shift = s[N-1:0];
  end else begin : g_many
    assign sum_shift = {s[N-1:0], sum_q[W-1:N]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid && in_ready_q) begin
            a_q        <= in_a;
            b_q        <= in_b;
            carry_q    <= in_cin;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= StRun;
          end
        end
        StRun: begin
          a_q          <= a_q >> N;
          b_q          <= b_q >> N;
          sum_q[W-1:0] <= sum_shift;
          carry_q      <= s[N];
          if (idx_q == LastIdx) begin
            sum_q[W]    <= s[N];
            idx_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_sum   = sum_q;

endmodule
